usb_tx_packetizer: RTL and testbench
====================================

// Module: usb_tx_packetizer
// PURPOSE
// - Transmit-side packet builder for the USB link layer. Turns a request into a byte stream for the NRZI/bit-stuff serializer.
// - Request types: TOKEN (PID+addr+endp+CRC5), DATA (PID+payload+CRC16) or HANDSHAKE (PID only).
// - Emits tx_con_pid_en at packet start and tx_lp_eop_en at packet end. These are the turnaround/timeout events the link controller consumes.
// PARAMETERS
// - SYNC_BYTE    8'h80  SYNC pattern sent before PID (only with USB_TX_SYNC_EN)
// - MAX_PAYLOAD  1023   max DATA payload bytes; payload_cnt is 10 bits
// PORTS
// - clk            in   1   clock
// - rst_n          in   1   asynchronous, active-low reset
// - tx_en          in   1   bus direction grant (link d_oe); 1 = may transmit
// - req            in   1   start request, sampled in IDLE only
// - req_pid        in   4   PID; [1:0]=01 token, 11 data, 10/00 PID-only
// - tok_addr       in   7   token address, latched at accept
// - tok_endp       in   4   token endpoint, latched at accept
// - pl_data        in   8   payload byte
// - pl_valid       in   1   payload byte valid
// - pl_last        in   1   marks final payload byte
// - pl_ready       out  1   payload byte consumed this cycle
// - tx_byte        out  8   byte to serializer (LSB sent first)
// - tx_valid       out  1   tx_byte valid
// - tx_eop         out  1   request EOP from serializer (held until tx_ready)
// - tx_ready       in   1   serializer accepts byte/EOP this cycle
// - busy           out  1   high from accept until return to IDLE
// - tx_con_pid_en  out  1   1-cycle pulse when PID byte is accepted
// - tx_con_pid     out  4   latched PID, valid from accept onward
// - tx_lp_eop_en   out  1   1-cycle pulse when EOP is accepted
// - tx_abort       out  1   1-cycle pulse on abort (tx_en drop / underrun)
// BEHAVIOUR
// - Reset: all outputs 0, tx_con_pid 4'h0, FSM IDLE, CRC regs all-ones.
// - FSM: IDLE -> [SYNC] -> PID -> {TOK0, TOK1 | DATA, CRC_LO, CRC_HI | -} -> EOP -> IDLE.
// - Accept: in IDLE with req && tx_en. Latch PID/addr/endp; busy=1 next cycle. req ignored while busy.
// - Each byte state drives tx_valid=1. It advances on the cycle tx_valid && tx_ready; one byte per handshake.
// - PID byte = {~pid, pid}. tx_con_pid_en pulses in the cycle the PID byte is accepted.
// - CRC5: poly x^5+x^2+1, init 5'h1F, LSB-first over {endp,addr}, result inverted.
//   - TOK0 = {endp[0], addr[6:0]}; TOK1 = {crc5[4:0], endp[3:1]}.
// - CRC16: poly 0x8005, init 16'hFFFF, LSB-first over payload, inverted.
//   - CRC_LO sends bits [7:0], then CRC_HI sends [15:8].
// - DATA: tx_byte=pl_data, tx_valid=pl_valid, pl_ready=tx_ready&&pl_valid.
//   - pl_last or the MAX_PAYLOAD-th byte -> CRC_LO.
//   - Zero-length packet: pl_last asserted with pl_valid=0 on entry -> straight to CRC_LO; CRC bytes 8'h00, 8'h00.
// - Underrun: in DATA, tx_ready=1 while pl_valid=0 and no pending pl_last -> abort.
// - EOP: tx_eop=1, tx_valid=0 until tx_ready. That cycle pulses tx_lp_eop_en; next state IDLE.
// - Abort: tx_en=0 in any non-IDLE state, or underrun.
//   - tx_abort pulses, FSM goes IDLE, no tx_lp_eop_en, CRC regs reinit.
//   - tx_en drop has priority over a same-cycle byte handshake.
// - req in the same cycle as EOP completion is ignored; it must be re-presented in IDLE.
// - Reset mid-packet: immediate return to reset values, no pulses.
// CONFIGURATION
// - USB_TX_SYNC_EN defined: SYNC state sends SYNC_BYTE before PID. tx_con_pid_en still fires on the PID byte.
// - USB_TX_SYNC_EN undefined: IDLE -> PID directly; serializer owns SYNC generation.
// STRUCTURE
// - Package usb_pkg: PID constants (OUT 4'b0001, IN 4'b1001, ACK 4'b0010, DATA0 4'b0011), packet-type decode, CRC poly/init constants.
// - Sub-module usb_crc_gen (byte-wide CRC5/CRC16 step, parameterised width). FSM and counters stay in the top module.
// TESTING
// - Handshake: ACK, tx_ready=1 -> bytes 8'hD2, EOP; pid_en and eop_en 1 pulse each.
// - Token: OUT addr 7'h15, endp 4'hE -> bytes 8'hE1, 8'h15, 8'hBF, EOP (CRC5 5'h17).
// - Zero-length DATA0 -> bytes 8'hC3, 8'h00, 8'h00, EOP; pl_ready never high.
// - DATA0 00 01 02 03 with random tx_ready/pl_valid gaps (no underrun) -> payload unchanged; CRC bytes match bitwise golden model.
// - tx_en low after 2nd payload byte -> tx_abort pulse, IDLE next cycle, no tx_lp_eop_en; next request produces correct CRC.
// - With USB_TX_SYNC_EN: first byte 8'h80; tx_con_pid_en aligned to PID byte, not SYNC.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: PID constants, packet-type decode,
// CRC polynomials/seeds and the transmit FSM state encoding.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    PKT_TOKEN,
    PKT_DATA,
    PKT_HANDSHAKE
  } pkt_type_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOK0,
    ST_TOK1,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP
  } tx_state_e;

  // The two low PID bits select the packet layout that follows the PID byte.
  function automatic pkt_type_e pid_type(input logic [3:0] pid);
    case (pid[1:0])
      2'b01:   return PKT_TOKEN;
      2'b11:   return PKT_DATA;
      default: return PKT_HANDSHAKE;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc_gen.sv
// Word-wide CRC accumulator. Input bits enter LSB first; the register shifts
// towards the MSB with POLY feedback. The output is the inverted register.
module usb_crc_gen #(
  parameter int               WIDTH  = 5,
  parameter int               DATA_W = 8,
  parameter logic [WIDTH-1:0] POLY   = '0,
  parameter logic [WIDTH-1:0] INIT   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [WIDTH-1:0]  crc
);

  logic [WIDTH-1:0] crc_reg;
  logic [WIDTH-1:0] crc_next;

  // Reseed on init, then optionally fold the whole data word in one cycle.
  always_comb begin
    crc_next = init ? INIT : crc_reg;
    if (en) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (crc_next[WIDTH-1] ^ data[i]) begin
          crc_next = {crc_next[WIDTH-2:0], 1'b0} ^ POLY;
        end else begin
          crc_next = {crc_next[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= INIT;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc = ~crc_reg;

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB transmit packet builder: turns a token/data/handshake request into a
// byte stream with PID, token fields or payload, CRC and an EOP request.
// Optional feature macro: USB_TX_SYNC_EN -- when defined, a SYNC byte is sent
// ahead of the PID; otherwise the serializer is expected to generate SYNC.
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'h80,
  parameter int         MAX_PAYLOAD = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       req,
  input  logic [3:0] req_pid,
  input  logic [6:0] tok_addr,
  input  logic [3:0] tok_endp,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       tx_eop,
  input  logic       tx_ready,
  output logic       busy,
  output logic       tx_con_pid_en,
  output logic [3:0] tx_con_pid,
  output logic       tx_lp_eop_en,
  output logic       tx_abort
);

  tx_state_e   state;
  tx_state_e   state_next;
  logic [3:0]  pid_reg;
  logic [6:0]  addr_reg;
  logic [3:0]  endp_reg;
  logic [9:0]  cnt_reg;
  logic        accept;
  logic        pl_take;
  logic        crc_clear;
  logic        link_drop;
  logic [4:0]  crc5;
  logic [15:0] crc16;

  // CRC5 is computed in one step from the live token inputs at accept time.
  usb_crc_gen #(
    .WIDTH (5),
    .DATA_W(11),
    .POLY  (CRC5_POLY),
    .INIT  (CRC5_INIT)
  ) u_crc5 (
    .clk  (clk),
    .rst_n(rst_n),
    .init (crc_clear),
    .en   (accept),
    .data ({tok_endp, tok_addr}),
    .crc  (crc5)
  );

  // CRC16 accumulates each payload byte as it is handed to the serializer.
  usb_crc_gen #(
    .WIDTH (16),
    .DATA_W(8),
    .POLY  (CRC16_POLY),
    .INIT  (CRC16_INIT)
  ) u_crc16 (
    .clk  (clk),
    .rst_n(rst_n),
    .init (crc_clear),
    .en   (pl_take),
    .data (pl_data),
    .crc  (crc16)
  );

  assign link_drop  = (state != ST_IDLE) && !tx_en;
  assign busy       = (state != ST_IDLE);
  assign tx_con_pid = pid_reg;

  // Next-state and output decode; a bus-grant drop overrides everything else.
  always_comb begin
    state_next    = state;
    tx_byte       = 8'h00;
    tx_valid      = 1'b0;
    tx_eop        = 1'b0;
    pl_ready      = 1'b0;
    tx_con_pid_en = 1'b0;
    tx_lp_eop_en  = 1'b0;
    tx_abort      = 1'b0;
    accept        = 1'b0;
    pl_take       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && tx_en) begin
          accept = 1'b1;
`ifdef USB_TX_SYNC_EN
          state_next = ST_SYNC;
`else
          state_next = ST_PID;
`endif
        end
      end
      ST_SYNC: begin
        tx_byte  = SYNC_BYTE;
        tx_valid = 1'b1;
        if (tx_ready) state_next = ST_PID;
      end
      ST_PID: begin
        tx_byte  = {~pid_reg, pid_reg};
        tx_valid = 1'b1;
        if (tx_ready) begin
          tx_con_pid_en = 1'b1;
          case (pid_type(pid_reg))
            PKT_TOKEN: state_next = ST_TOK0;
            PKT_DATA:  state_next = ST_DATA;
            default:   state_next = ST_EOP;
          endcase
        end
      end
      ST_TOK0: begin
        tx_byte  = {endp_reg[0], addr_reg};
        tx_valid = 1'b1;
        if (tx_ready) state_next = ST_TOK1;
      end
      ST_TOK1: begin
        tx_byte  = {crc5, endp_reg[3:1]};
        tx_valid = 1'b1;
        if (tx_ready) state_next = ST_EOP;
      end
      ST_DATA: begin
        tx_byte  = pl_data;
        tx_valid = pl_valid;
        if (pl_valid && tx_ready) begin
          pl_ready = 1'b1;
          pl_take  = 1'b1;
          if (pl_last || (cnt_reg == 10'(MAX_PAYLOAD - 1))) state_next = ST_CRC_LO;
        end else if (!pl_valid && pl_last) begin
          // End of payload flagged with no byte attached (zero-length packet).
          state_next = ST_CRC_LO;
        end else if (!pl_valid && tx_ready) begin
          // Serializer wants a byte we do not have: underrun.
          tx_abort   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_CRC_LO: begin
        tx_byte  = crc16[7:0];
        tx_valid = 1'b1;
        if (tx_ready) state_next = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        tx_byte  = crc16[15:8];
        tx_valid = 1'b1;
        if (tx_ready) state_next = ST_EOP;
      end
      ST_EOP: begin
        tx_eop = 1'b1;
        if (tx_ready) begin
          tx_lp_eop_en = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (link_drop) begin
      state_next    = ST_IDLE;
      tx_abort      = 1'b1;
      pl_ready      = 1'b0;
      pl_take       = 1'b0;
      tx_con_pid_en = 1'b0;
      tx_lp_eop_en  = 1'b0;
    end
  end

  // Both CRCs are held at their seed while idle and reseeded on any abort.
  assign crc_clear = (state == ST_IDLE) || tx_abort;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields are captured once at accept and held for the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_reg  <= 4'h0;
      addr_reg <= 7'h00;
      endp_reg <= 4'h0;
    end else if (accept) begin
      pid_reg  <= req_pid;
      addr_reg <= tok_addr;
      endp_reg <= tok_endp;
    end
  end

  // Payload byte counter bounds a DATA packet at MAX_PAYLOAD bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 10'd0;
    end else if (accept) begin
      cnt_reg <= 10'd0;
    end else if (pl_take) begin
      cnt_reg <= cnt_reg + 10'd1;
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Self-checking bench for usb_tx_packetizer: randomized handshakes against a
// packet-level reference (expected byte list built from field layout + CRC).
module tb_usb_tx_packetizer;

`ifdef USB_TX_SYNC_EN
  localparam int SO = 1;
`else
  localparam int SO = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       req;
  logic [3:0] req_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_last;
  logic       pl_ready;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_eop;
  logic       tx_ready;
  logic       busy;
  logic       tx_con_pid_en;
  logic [3:0] tx_con_pid;
  logic       tx_lp_eop_en;
  logic       tx_abort;

  int checks = 0;
  int errors = 0;

  logic [7:0] pl_q[$];
  bit         bits_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  usb_tx_packetizer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .req          (req),
    .req_pid      (req_pid),
    .tok_addr     (tok_addr),
    .tok_endp     (tok_endp),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_last      (pl_last),
    .pl_ready     (pl_ready),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_eop       (tx_eop),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .tx_con_pid_en(tx_con_pid_en),
    .tx_con_pid   (tx_con_pid),
    .tx_lp_eop_en (tx_lp_eop_en),
    .tx_abort     (tx_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC over bits_q (first element transmitted first), inverted.
  function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly,
                                          input logic [31:0] init);
    logic [31:0] r, mask, top;
    mask = (32'd1 << w) - 32'd1;
    top  = 32'd1 << (w - 1);
    r    = init;
    foreach (bits_q[i]) begin
      if (((r & top) != 0) != bits_q[i]) r = ((r << 1) ^ poly) & mask;
      else                               r = (r << 1) & mask;
    end
    return ~r & mask;
  endfunction

  function automatic logic [8:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 9'h1FF;
  endfunction

  task automatic fill_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  task automatic drive_idle();
    req = 1'b0; req_pid = 4'h0; tok_addr = 7'h00; tok_endp = 4'h0;
    pl_data = 8'h00; pl_valid = 1'b0; pl_last = 1'b0; tx_ready = 1'b0; tx_en = 1'b1;
  endtask

  // One packet: build expected stream, drive handshakes, compare at the end.
  task automatic run_pkt(input string tag, input logic [3:0] pid, input logic [6:0] addr,
                         input logic [3:0] endp, input bit use_last, input int rdy_pct,
                         input int gap_pct, input int abort_at, input bit underrun);
    int pidx = 0, npid = 0, neop = 0, nabort = 0, nready = 0;
    bit done = 0, issued = 0, hold_req;
    logic [31:0] c;
    logic [4:0]  c5;
    exp_q.delete();
    got_q.delete();
`ifdef USB_TX_SYNC_EN
    exp_q.push_back(9'h080);
`endif
    exp_q.push_back({1'b0, ~pid, pid});
    if (pid[1:0] == 2'b01) begin
      bits_q.delete();
      for (int i = 0; i < 7; i++) bits_q.push_back(addr[i]);
      for (int i = 0; i < 4; i++) bits_q.push_back(endp[i]);
      c  = crc_ref(5, 32'h05, 32'h1F);
      c5 = c[4:0];
      exp_q.push_back({1'b0, endp[0], addr});
      exp_q.push_back({1'b0, c5, endp[3:1]});
    end else if (pid[1:0] == 2'b11) begin
      bits_q.delete();
      foreach (pl_q[k]) begin
        exp_q.push_back({1'b0, pl_q[k]});
        for (int i = 0; i < 8; i++) bits_q.push_back(pl_q[k][i]);
      end
      c = crc_ref(16, 32'h8005, 32'hFFFF);
      exp_q.push_back({1'b0, c[7:0]});
      exp_q.push_back({1'b0, c[15:8]});
    end
    exp_q.push_back(9'h100);

    hold_req = 1'($urandom_range(1));
    @(posedge clk); #1;
    drive_idle();
    req = 1'b1; req_pid = pid; tok_addr = addr; tok_endp = endp;
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      @(posedge clk); #1;
      req      = hold_req;
      req_pid  = 4'($urandom);
      tok_addr = 7'($urandom);
      tok_endp = 4'($urandom);
      tx_en    = 1'b1;
      tx_ready = ($urandom_range(99) < rdy_pct);
      if (pidx < pl_q.size()) begin
        pl_data = pl_q[pidx];
        if ($urandom_range(99) < gap_pct) begin
          pl_valid = 1'b0; pl_last = 1'b0; tx_ready = 1'b0;
        end else begin
          pl_valid = 1'b1; pl_last = use_last && (pidx == pl_q.size() - 1);
        end
      end else begin
        pl_data  = 8'($urandom);
        pl_valid = 1'b0;
        pl_last  = use_last && (pl_q.size() == 0);
      end
      if (abort_at >= 0 && !issued && pidx == abort_at) begin
        issued = 1;
        if (underrun) begin
          pl_valid = 1'b0; pl_last = 1'b0; tx_ready = 1'b1;
        end else begin
          tx_en = 1'b0;
        end
      end
      @(negedge clk);
      if (cyc == 0) check({tag, "_busy_accept"}, 32'(busy), 32'd1);
      if (tx_valid && tx_ready && tx_en) got_q.push_back({1'b0, tx_byte});
      if (tx_eop && tx_ready && tx_en) got_q.push_back(9'h100);
      if (tx_con_pid_en) begin
        npid++;
        check({tag, "_pid_align"}, 32'({tx_valid, tx_byte}), 32'({1'b1, ~pid, pid}));
      end
      if (tx_lp_eop_en) neop++;
      if (tx_abort) nabort++;
      if (pl_ready) begin
        nready++;
        pidx++;
      end
      if (tx_lp_eop_en || tx_abort) done = 1;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_pulse_clear"}, 32'({tx_abort, tx_lp_eop_en, tx_con_pid_en}), 32'd0);
    check({tag, "_con_pid"}, 32'(tx_con_pid), 32'(pid));
    if (abort_at >= 0) begin
      check({tag, "_abort_cnt"}, 32'(nabort), 32'd1);
      check({tag, "_eop_on_abort"}, 32'(neop), 32'd0);
    end else begin
      check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) check({tag, "_byte"}, 32'(got_at(i)), 32'(exp_q[i]));
      check({tag, "_pid_en_cnt"}, 32'(npid), 32'd1);
      check({tag, "_eop_en_cnt"}, 32'(neop), 32'd1);
      check({tag, "_abort_cnt"}, 32'(nabort), 32'd0);
      check({tag, "_pl_ready_cnt"}, 32'(nready), 32'(pl_q.size()));
    end
    $display("pkt %s pid=%h payload=%0d bytes_seen=%0d aborted=%0d", tag, pid, pl_q.size(),
             got_q.size(), nabort);
  endtask

  logic [3:0] pid_tab[6] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b1011, 4'b1010};

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({busy, tx_valid, tx_eop, pl_ready, tx_con_pid_en,
                              tx_lp_eop_en, tx_abort}), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_con_pid", 32'(tx_con_pid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Handshake ACK with serializer always ready.
    pl_q.delete();
    run_pkt("ack", 4'b0010, 7'h00, 4'h0, 1, 100, 0, -1, 0);
    check("ack_pid_byte", 32'(got_at(SO)), 32'h0D2);
`ifdef USB_TX_SYNC_EN
    check("ack_sync_byte", 32'(got_at(0)), 32'h080);
`endif

    // Token OUT addr 0x15 endp 0xE.
    run_pkt("tok", 4'b0001, 7'h15, 4'hE, 1, 70, 0, -1, 0);
    check("tok_b0", 32'(got_at(SO)), 32'h0E1);
    check("tok_b1", 32'(got_at(SO + 1)), 32'h015);
    check("tok_b2", 32'(got_at(SO + 2)), 32'h0BF);

    // Zero-length DATA0.
    pl_q.delete();
    run_pkt("zlp", 4'b0011, 7'h00, 4'h0, 1, 80, 0, -1, 0);
    check("zlp_crc_lo", 32'(got_at(SO + 1)), 32'h000);
    check("zlp_crc_hi", 32'(got_at(SO + 2)), 32'h000);

    // DATA0 00 01 02 03 with random gaps.
    pl_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    run_pkt("d4", 4'b0011, 7'h00, 4'h0, 1, 60, 30, -1, 0);

    // Bus grant dropped after the second payload byte, then a clean packet.
    fill_payload(6);
    run_pkt("drop", 4'b0011, 7'h00, 4'h0, 1, 100, 0, 2, 0);
    fill_payload(5);
    run_pkt("after_drop", 4'b1011, 7'h00, 4'h0, 1, 75, 20, -1, 0);

    // Underrun: serializer ready with no payload byte and no pending last.
    fill_payload(5);
    run_pkt("underrun", 4'b0011, 7'h00, 4'h0, 1, 100, 0, 1, 0 | 1);
    fill_payload(3);
    run_pkt("after_under", 4'b0011, 7'h00, 4'h0, 1, 90, 10, -1, 0);

    // Randomized mix of packet types.
    for (int n = 0; n < 20; n++) begin
      logic [3:0] p;
      p = pid_tab[$urandom_range(5)];
      if (p[1:0] == 2'b11) fill_payload($urandom_range(20));
      else pl_q.delete();
      run_pkt("rand", p, 7'($urandom), 4'($urandom), 1, $urandom_range(40, 100),
              $urandom_range(0, 40), -1, 0);
    end

    // Maximum payload with no pl_last: the byte counter must close the packet.
    fill_payload(1023);
    run_pkt("max", 4'b0011, 7'h00, 4'h0, 0, 100, 0, -1, 0);

    // Asynchronous reset in the middle of a packet.
    @(posedge clk); #1;
    drive_idle();
    req = 1'b1; req_pid = 4'b0010;
    @(posedge clk); #1;
    req = 1'b0;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({busy, tx_valid, tx_eop, tx_con_pid_en, tx_lp_eop_en,
                                  tx_abort}), 32'd0);
    check("mid_rst_con_pid", 32'(tx_con_pid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pl_q.delete();
    run_pkt("post_rst", 4'b1001, 7'h7F, 4'h1, 1, 100, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
